// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;
   typedef enum logic {BLANK, DRIVE} scan_state_t;
   localparam logic [6:0] SEG_OFF    = 7'b0000000;
   localparam logic [3:0] DIGIT_BITS = 4;
endpackage

// File: rtl/seg7_scan_ctrl_bin2seg.sv
// Binary-to-7-segment decoder, {a,b,c,d,e,f,g} active-high.
// Codes 10..15 have no glyph and render as "0".
module binary_to_7segm (
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);
   always_comb begin
      seg_o = 7'b1111110;
      case (code_i)
         4'd0:    seg_o = 7'b1111110;
         4'd1:    seg_o = 7'b0110000;
         4'd2:    seg_o = 7'b1101101;
         4'd3:    seg_o = 7'b1111001;
         4'd4:    seg_o = 7'b0110011;
         4'd5:    seg_o = 7'b1011011;
         4'd6:    seg_o = 7'b1011111;
         4'd7:    seg_o = 7'b1110000;
         4'd8:    seg_o = 7'b1111111;
         4'd9:    seg_o = 7'b1111011;
         default: seg_o = 7'b1111110;
      endcase
   end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of an N-digit common-anode display with per-slot blanking
// and frame-synchronous double buffering of the displayed value.
//
// state | meaning
// BLANK | leading part of a digit slot, all anodes off
// DRIVE | remainder of the slot, selected digit lit unless masked
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 27000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 load_i,
   input  logic [int'(DIGIT_BITS)*N_DIGITS-1:0] value_i,
   input  logic [N_DIGITS-1:0]                  blank_mask_i,
   output logic [N_DIGITS-1:0]                  anodes_o,
   output logic [6:0]                           segments_o,
   output logic                                 frame_o,
   output logic                                 load_ack_o
);
   localparam int DW    = int'(DIGIT_BITS);
   localparam int VAL_W = DW * N_DIGITS;
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   scan_state_t         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VAL_W-1:0]    active_q, active_d;
   logic [VAL_W-1:0]    pending_q, pending_d;
   logic                pvalid_q, pvalid_d;
   logic [N_DIGITS-1:0] anodes_q, anodes_d;
   logic [6:0]          segments_q, segments_d;
   logic                frame_q, frame_d;
   logic                ack_q, ack_d;

   logic       slot_end;
   logic       frame_end;
   logic [3:0] digit_code;
   logic [6:0] dec_seg;

   binary_to_7segm u_dec (
      .code_i (digit_code),
      .seg_o  (dec_seg)
   );

   always_comb begin
      slot_end   = (cnt_q == CNT_LAST);
      frame_end  = slot_end && (idx_q == IDX_LAST);
      cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      state_d    = state_q;
      active_d   = active_q;
      pending_d  = pending_q;
      pvalid_d   = pvalid_q;
      ack_d      = 1'b0;
      frame_d    = frame_end;
      anodes_d   = '1;
      segments_d = SEG_OFF;
      digit_code = '0;

      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      case (state_q)
         BLANK:   if (cnt_q == BLANK_LAST) state_d = DRIVE;
         DRIVE:   if (slot_end) state_d = BLANK;
         default: state_d = BLANK;
      endcase

      // A load landing on the boundary cycle skips pending and commits directly.
      if (frame_end) begin
         if (load_i) begin
            active_d = value_i;
            pvalid_d = 1'b0;
            ack_d    = 1'b1;
         end else if (pvalid_q) begin
            active_d = pending_q;
            pvalid_d = 1'b0;
            ack_d    = 1'b1;
         end
      end else if (load_i) begin
         pending_d = value_i;
         pvalid_d  = 1'b1;
      end

      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) digit_code = active_q[k*DW +: DW];
      end

      // Anodes and segments come from the same state so both pins switch on one edge.
      if ((state_q == DRIVE) && !blank_mask_i[idx_q]) begin
         anodes_d[idx_q] = 1'b0;
         segments_d      = dec_seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BLANK;
         cnt_q      <= '0;
         idx_q      <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         pvalid_q   <= 1'b0;
         anodes_q   <= '1;
         segments_q <= SEG_OFF;
         frame_q    <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         pvalid_q   <= pvalid_d;
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
         frame_q    <= frame_d;
         ack_q      <= ack_d;
      end
   end

   assign anodes_o   = anodes_q;
   assign segments_o = segments_q;
   assign frame_o    = frame_q;
   assign load_ack_o = ack_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// cyc counts rising edges since reset release; pins at cyc k reflect slot position k-1.
module tb_seg7_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_i;
   logic [15:0] value_i;
   logic [3:0]  blank_mask_i;
   logic [3:0]  anodes_o;
   logic [6:0]  segments_o;
   logic        frame_o;
   logic        load_ack_o;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int ack_cnt = 0;

   seg7_scan_ctrl #(
      .N_DIGITS     (4),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load_i),
      .value_i      (value_i),
      .blank_mask_i (blank_mask_i),
      .anodes_o     (anodes_o),
      .segments_o   (segments_o),
      .frame_o      (frame_o),
      .load_ack_o   (load_ack_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pins(input string tag, input logic [3:0] an, input logic [6:0] sg);
      chk({tag, "_an"}, 32'(anodes_o), 32'(an));
      chk({tag, "_seg"}, 32'(segments_o), 32'(sg));
   endtask

   task automatic wait_cyc(input int t);
      int guard = 0;
      while (cyc != t && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != t) chk("wait_timeout", 32'(cyc), 32'(t));
   endtask

   // Invariants checked on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n && cyc >= 1) begin
         chk("at_most_one_anode", 32'($countones(~anodes_o) <= 1), 32'd1);
         if (((cyc - 1) % 8) < 2) begin
            chk("slot_gap_an", 32'(anodes_o), 32'hF);
            chk("slot_gap_seg", 32'(segments_o), 32'h0);
         end
         chk("frame_pulse", 32'(frame_o), 32'((cyc % 32) == 0));
         if (load_ack_o) begin
            ack_cnt++;
            chk("ack_with_frame", 32'(frame_o), 32'd1);
         end
      end
   end

   initial begin
      rst_n = 1'b0; load_i = 1'b0; value_i = '0; blank_mask_i = '0;
      repeat (5) @(negedge clk);
      chk_pins("rst", 4'hF, 7'h00);
      chk("rst_frame", 32'(frame_o), 32'd0);
      chk("rst_ack", 32'(load_ack_o), 32'd0);
      rst_n = 1'b1;

      wait_cyc(1);  chk_pins("c1_blank", 4'hF, 7'h00);
      wait_cyc(3);  chk_pins("c3_first_drive", 4'hE, 7'b1111110);

      wait_cyc(10); load_i = 1'b1; value_i = 16'h1234;
      wait_cyc(11); load_i = 1'b0;
      chk_pins("mid_d1_old", 4'hD, 7'b1111110);
      wait_cyc(19); chk_pins("mid_d2_old", 4'hB, 7'b1111110);
      wait_cyc(32); chk("ack_1234", 32'(load_ack_o), 32'd1);
      wait_cyc(33); chk("ack_1234_end", 32'(load_ack_o), 32'd0);
      wait_cyc(35); chk_pins("d0_4", 4'hE, 7'b0110011);
      wait_cyc(43); chk_pins("d1_3", 4'hD, 7'b1111001);
      wait_cyc(51); chk_pins("d2_2", 4'hB, 7'b1101101);
      wait_cyc(59); chk_pins("d3_1", 4'h7, 7'b0110000);
      wait_cyc(64); chk("no_ack_idle_frame", 32'(load_ack_o), 32'd0);

      wait_cyc(66); load_i = 1'b1; value_i = 16'h5555;
      wait_cyc(67); load_i = 1'b0;
      wait_cyc(70); load_i = 1'b1; value_i = 16'h9876;
      wait_cyc(71); load_i = 1'b0;
      wait_cyc(75); chk_pins("pending_hidden", 4'hD, 7'b1111001);
      wait_cyc(96); chk("ack_9876", 32'(load_ack_o), 32'd1);
      wait_cyc(99);  chk_pins("d0_6", 4'hE, 7'b1011111);
      wait_cyc(107); chk_pins("d1_7", 4'hD, 7'b1110000);
      wait_cyc(115); chk_pins("d2_8", 4'hB, 7'b1111111);
      wait_cyc(123); chk_pins("d3_9", 4'h7, 7'b1111011);
      chk("ack_count_two_loads", 32'(ack_cnt), 32'd2);

      wait_cyc(127); load_i = 1'b1; value_i = 16'h000A;
      wait_cyc(128); load_i = 1'b0;
      chk("ack_boundary_load", 32'(load_ack_o), 32'd1);
      wait_cyc(131); chk_pins("d0_code10", 4'hE, 7'b1111110);
      wait_cyc(139); chk_pins("d1_zero", 4'hD, 7'b1111110);
      chk("ack_count_bypass", 32'(ack_cnt), 32'd3);

      wait_cyc(140); blank_mask_i = 4'b0100;
      wait_cyc(143); chk_pins("mask_d1_lit", 4'hD, 7'b1111110);
      for (int c = 147; c <= 152; c++) begin
         wait_cyc(c);
         chk_pins("mask_d2_dark", 4'hF, 7'h00);
      end
      wait_cyc(155); chk_pins("mask_d3_lit", 4'h7, 7'b1111110);
      wait_cyc(159); blank_mask_i = 4'b0000;

      wait_cyc(165); load_i = 1'b1; value_i = 16'h8888;
      wait_cyc(166); load_i = 1'b0;
      wait_cyc(180); chk_pins("pre_reset_d2", 4'hB, 7'b1111110);
      wait_cyc(181);
      rst_n = 1'b0;
      #1;
      chk_pins("async_reset", 4'hF, 7'h00);
      chk("async_reset_frame", 32'(frame_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      wait_cyc(3);  chk_pins("post_d0", 4'hE, 7'b1111110);
      wait_cyc(11); chk_pins("post_d1", 4'hD, 7'b1111110);
      wait_cyc(19); chk_pins("post_d2", 4'hB, 7'b1111110);
      wait_cyc(27); chk_pins("post_d3", 4'h7, 7'b1111110);
      wait_cyc(32); chk("post_no_ack", 32'(load_ack_o), 32'd0);
      wait_cyc(35); chk_pins("post_lost_load", 4'hE, 7'b1111110);
      chk("ack_count_final", 32'(ack_cnt), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
